// File: rtl/pll_reset_sequencer.sv
// PLL reset/lock bring-up sequencer producing a lock-qualified system reset on refclk.
// Optional lock-loss counter is built when PLL_SEQ_LOSS_COUNT_EN is defined.
module pll_reset_sequencer #(
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 100000,
    parameter int STABLE_CYCLES = 1024,
    parameter int MAX_RETRIES   = 3,
    parameter int TIMER_W       = 20
) (
    input  logic       refclk,
    input  logic       rst,
    input  logic       pll_locked,
    input  logic       relock_req,
    output logic       pll_rst,
    output logic       sys_rst,
    output logic       fail,
    output logic [2:0] state,
    output logic [7:0] loss_count
);

    localparam int RETRY_W = (MAX_RETRIES < 1) ? 1 : $clog2(MAX_RETRIES + 1);

    localparam logic [TIMER_W-1:0] RST_LAST     = TIMER_W'(RST_CYCLES - 1);
    localparam logic [TIMER_W-1:0] TIMEOUT_LAST = TIMER_W'(LOCK_TIMEOUT - 1);
    localparam logic [TIMER_W-1:0] STABLE_LAST  = TIMER_W'(STABLE_CYCLES - 1);
    localparam logic [TIMER_W-1:0] TIMER_ONE    = TIMER_W'(1);
    localparam logic [RETRY_W-1:0] RETRY_MAX    = RETRY_W'(MAX_RETRIES);
    localparam logic [RETRY_W-1:0] RETRY_ONE    = RETRY_W'(1);

    typedef enum logic [2:0] {
        RESET_PLL = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        RUN       = 3'd3,
        FAIL      = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic [RETRY_W-1:0] retry_q, retry_d;
    logic               lk_m, lk_s;
    logic               lock_lost;

    // pll_locked is asynchronous to refclk; only lk_s is used for decisions.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            lk_m <= 1'b0;
            lk_s <= 1'b0;
        end else begin
            lk_m <= pll_locked;
            lk_s <= lk_m;
        end
    end

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q + TIMER_ONE;
        retry_d   = retry_q;
        lock_lost = 1'b0;
        if (relock_req) begin
            state_d = RESET_PLL;
            timer_d = '0;
            retry_d = '0;
        end else begin
            case (state_q)
                RESET_PLL: begin
                    if (timer_q == RST_LAST) begin
                        state_d = WAIT_LOCK;
                        timer_d = '0;
                    end
                end
                WAIT_LOCK: begin
                    if (lk_s) begin
                        state_d = STABLE;
                        timer_d = '0;
                    end else if (timer_q == TIMEOUT_LAST) begin
                        timer_d = '0;
                        if (retry_q < RETRY_MAX) begin
                            retry_d = retry_q + RETRY_ONE;
                            state_d = RESET_PLL;
                        end else begin
                            state_d = FAIL;
                        end
                    end
                end
                STABLE: begin
                    // A lock drop beats a coincident terminal count.
                    if (!lk_s) begin
                        state_d = WAIT_LOCK;
                        timer_d = '0;
                    end else if (timer_q == STABLE_LAST) begin
                        state_d = RUN;
                        timer_d = '0;
                        retry_d = '0;
                    end
                end
                RUN: begin
                    timer_d = '0;
                    if (!lk_s) begin
                        state_d   = RESET_PLL;
                        lock_lost = 1'b1;
                    end
                end
                FAIL: begin
                    timer_d = '0;
                end
                default: begin
                    state_d = RESET_PLL;
                    timer_d = '0;
                end
            endcase
        end
    end

    // Outputs decode state_d so they switch on the same edge as state.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            state_q <= RESET_PLL;
            timer_q <= '0;
            retry_q <= '0;
            pll_rst <= 1'b1;
            sys_rst <= 1'b1;
            fail    <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            retry_q <= retry_d;
            pll_rst <= (state_d == RESET_PLL) || (state_d == FAIL);
            sys_rst <= (state_d != RUN);
            fail    <= (state_d == FAIL);
        end
    end

    assign state = state_q;

`ifdef PLL_SEQ_LOSS_COUNT_EN
    logic [7:0] loss_q;

    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            loss_q <= 8'd0;
        end else if (lock_lost && (loss_q != 8'hFF)) begin
            loss_q <= loss_q + 8'd1;
        end
    end

    assign loss_count = loss_q;
`else
    logic loss_unused;
    assign loss_unused = lock_lost;
    assign loss_count  = 8'd0;
`endif

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench for pll_reset_sequencer: phase-level reference model checked every cycle,
// plus hand-computed latency/pulse-width expectations from the test plan.
module tb_pll_reset_sequencer;

    localparam int RST_CYCLES    = 4;
    localparam int LOCK_TIMEOUT  = 20;
    localparam int STABLE_CYCLES = 8;
    localparam int MAX_RETRIES   = 2;
    localparam int TIMER_W       = 20;

`ifdef PLL_SEQ_LOSS_COUNT_EN
    localparam bit LOSS_EN = 1'b1;
`else
    localparam bit LOSS_EN = 1'b0;
`endif

    localparam int P_RESET  = 0;
    localparam int P_WAIT   = 1;
    localparam int P_STABLE = 2;
    localparam int P_RUN    = 3;
    localparam int P_FAIL   = 4;

    logic       refclk = 1'b0;
    logic       rst = 1'b1;
    logic       pll_locked = 1'b0;
    logic       relock_req = 1'b0;
    logic       pll_rst;
    logic       sys_rst;
    logic       fail;
    logic [2:0] state;
    logic [7:0] loss_count;

    int checks = 0;
    int errors = 0;

    pll_reset_sequencer #(
        .RST_CYCLES   (RST_CYCLES),
        .LOCK_TIMEOUT (LOCK_TIMEOUT),
        .STABLE_CYCLES(STABLE_CYCLES),
        .MAX_RETRIES  (MAX_RETRIES),
        .TIMER_W      (TIMER_W)
    ) dut (
        .refclk    (refclk),
        .rst       (rst),
        .pll_locked(pll_locked),
        .relock_req(relock_req),
        .pll_rst   (pll_rst),
        .sys_rst   (sys_rst),
        .fail      (fail),
        .state     (state),
        .loss_count(loss_count)
    );

    always #5 refclk = ~refclk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: which phase we are in and how many edges we have spent there.
    int       m_phase = P_RESET;
    int       m_cycles = 0;
    int       m_timeouts = 0;
    int       m_losses = 0;
    bit [1:0] m_sync = 2'b00;

    task automatic enter(input int phase);
        m_phase  = phase;
        m_cycles = 0;
    endtask

    always @(posedge refclk or posedge rst) begin
        bit lk;
        if (rst) begin
            m_phase = P_RESET; m_cycles = 0; m_timeouts = 0; m_losses = 0; m_sync = 2'b00;
        end else begin
            lk = m_sync[1];
            m_sync = {m_sync[0], pll_locked};
            m_cycles++;
            if (relock_req) begin
                enter(P_RESET);
                m_timeouts = 0;
            end else if (m_phase == P_RESET) begin
                if (m_cycles == RST_CYCLES) enter(P_WAIT);
            end else if (m_phase == P_WAIT) begin
                if (lk) enter(P_STABLE);
                else if (m_cycles == LOCK_TIMEOUT) begin
                    if (m_timeouts < MAX_RETRIES) begin
                        m_timeouts++;
                        enter(P_RESET);
                    end else begin
                        enter(P_FAIL);
                    end
                end
            end else if (m_phase == P_STABLE) begin
                if (!lk) enter(P_WAIT);
                else if (m_cycles == STABLE_CYCLES) begin
                    enter(P_RUN);
                    m_timeouts = 0;
                end
            end else if (m_phase == P_RUN) begin
                if (!lk) begin
                    enter(P_RESET);
                    if (LOSS_EN && m_losses < 255) m_losses++;
                end
            end
        end
    end

    always @(negedge refclk) begin
        check("model_state", int'(state), m_phase);
        check("model_pll_rst", int'(pll_rst), int'(m_phase == P_RESET || m_phase == P_FAIL));
        check("model_sys_rst", int'(sys_rst), int'(m_phase != P_RUN));
        check("model_fail", int'(fail), int'(m_phase == P_FAIL));
        check("model_loss_count", int'(loss_count), m_losses);
    end

    task automatic tick();
        @(negedge refclk);
    endtask

    task automatic pulse_relock();
        relock_req = 1'b1;
        tick();
        relock_req = 1'b0;
    endtask

    task automatic wait_state(input int s, input int budget);
        int n;
        n = 0;
        while (int'(state) != s && n < budget) begin
            tick();
            n++;
        end
        checks++;
        if (int'(state) != s) begin
            errors++;
            $display("FAIL wait_state: state %0d never reached %0d within %0d cycles", state, s, budget);
        end
    endtask

    initial begin
        int hi, lat;
        bit saw_wait;

        repeat (2) tick();
        check("reset_state", int'(state), 0);
        check("reset_pll_rst", int'(pll_rst), 1);
        check("reset_sys_rst", int'(sys_rst), 1);
        check("reset_fail", int'(fail), 0);
        check("reset_loss", int'(loss_count), 0);

        // Clean bring-up: lock 10 cycles after reset release.
        rst = 1'b0;
        hi = 0;
        for (int i = 0; i < 10; i++) begin
            if (pll_rst) hi++;
            tick();
        end
        check("bringup_pll_rst_width", hi, RST_CYCLES);
        pll_locked = 1'b1;
        lat = -1;
        for (int i = 1; i <= 30; i++) begin
            tick();
            if (!sys_rst) begin
                lat = i;
                break;
            end
        end
        check("bringup_release_latency", lat, 11);
        check("bringup_state_run", int'(state), 3);

        // Glitch in STABLE forces a fresh stable count.
        pulse_relock();
        wait_state(P_STABLE, 40);
        repeat (4) tick();
        pll_locked = 1'b0;
        tick();
        pll_locked = 1'b1;
        lat = -1;
        saw_wait = 1'b0;
        for (int i = 1; i <= 30; i++) begin
            tick();
            if (int'(state) == P_WAIT) saw_wait = 1'b1;
            if (!sys_rst) begin
                lat = i;
                break;
            end
        end
        check("glitch_back_to_wait", int'(saw_wait), 1);
        check("glitch_release_latency", lat, 11);

        // Lock loss in RUN.
        pll_locked = 1'b0;
        lat = -1;
        for (int i = 1; i <= 6; i++) begin
            tick();
            if (sys_rst) begin
                lat = i;
                break;
            end
        end
        check("loss_sys_rst_latency", lat, 3);
        check("loss_state", int'(state), 0);
        check("loss_count_after_loss", int'(loss_count), LOSS_EN ? 1 : 0);
        repeat (2) tick();
        pll_locked = 1'b1;
        wait_state(P_RUN, 60);
        check("relock_sys_rst", int'(sys_rst), 0);

        // relock_req coincident with the STABLE terminal count wins.
        pulse_relock();
        wait_state(P_STABLE, 40);
        repeat (STABLE_CYCLES - 1) tick();
        pulse_relock();
        check("priority_state", int'(state), 0);

        // Timeouts, retries, FAIL.
        pll_locked = 1'b0;
        pulse_relock();
        for (int i = 0; i < 77; i++) begin
            check("retry_pll_rst_pattern", int'(pll_rst), (i < 72) ? int'((i % 24) < 4) : 1);
            tick();
        end
        check("fail_state", int'(state), 4);
        check("fail_flag", int'(fail), 1);
        check("fail_pll_rst", int'(pll_rst), 1);
        pulse_relock();
        check("fail_cleared", int'(fail), 0);
        check("fail_exit_state", int'(state), 0);

        // Asynchronous reset from RUN.
        pll_locked = 1'b1;
        wait_state(P_RUN, 60);
        @(posedge refclk);
        #2 rst = 1'b1;
        #1;
        check("async_sys_rst", int'(sys_rst), 1);
        check("async_pll_rst", int'(pll_rst), 1);
        check("async_loss", int'(loss_count), 0);
        check("async_state", int'(state), 0);
        tick();
        rst = 1'b0;
        repeat (3) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
